vip_axi4_rd_burst_ctrl: RTL and testbench

Read-transfer sequencer for an AXI4 master port. It accepts a command of (start address, beat count, ID) and splits it into INCR read bursts. Each burst is capped by MAX_BURST_LEN_P and never crosses a 4 KB boundary. It bounds outstanding bursts, forwards R beats to a streaming data output with backpressure, and reports one merged completion status per command.

---
 rtl/vip_axi4_types_pkg.sv | 54 +++++
 rtl/vip_axi4_burst_len_calc.sv | 31 +++
 rtl/vip_axi4_rd_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_vip_axi4_rd_burst_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_axi4_types_pkg.sv
// rtl/vip_axi4_types_pkg.sv - shared AXI4 VIP types, constants and helpers
package vip_axi4_types_pkg;

  localparam int          VIP_AXI4_MAX_LENGTH_C          = 256;
  localparam int          VIP_AXI4_4K_ADDRESS_BOUNDARY_C = 4096;
  localparam logic [1:0]  VIP_AXI4_BURST_INCR_C          = 2'b01;

  typedef enum logic [1:0] {
    VIP_AXI4_RESP_OKAY_C   = 2'b00,
    VIP_AXI4_RESP_EXOKAY_C = 2'b01,
    VIP_AXI4_RESP_SLVERR_C = 2'b10,
    VIP_AXI4_RESP_DECERR_C = 2'b11
  } vip_axi4_resp_t;

  typedef enum logic [2:0] {
    VIP_AXI4_SIZE_1B_C   = 3'd0,
    VIP_AXI4_SIZE_2B_C   = 3'd1,
    VIP_AXI4_SIZE_4B_C   = 3'd2,
    VIP_AXI4_SIZE_8B_C   = 3'd3,
    VIP_AXI4_SIZE_16B_C  = 3'd4,
    VIP_AXI4_SIZE_32B_C  = 3'd5,
    VIP_AXI4_SIZE_64B_C  = 3'd6,
    VIP_AXI4_SIZE_128B_C = 3'd7
  } vip_axi4_size_t;

  typedef enum logic [1:0] {
    VIP_AXI4_RD_IDLE_C  = 2'd0,
    VIP_AXI4_RD_ISSUE_C = 2'd1,
    VIP_AXI4_RD_DRAIN_C = 2'd2,
    VIP_AXI4_RD_DONE_C  = 2'd3
  } vip_axi4_rd_ctrl_state_t;

  function automatic vip_axi4_size_t size_as_enum(input int unsigned bytes);
    case (bytes)
      1:       return VIP_AXI4_SIZE_1B_C;
      2:       return VIP_AXI4_SIZE_2B_C;
      4:       return VIP_AXI4_SIZE_4B_C;
      8:       return VIP_AXI4_SIZE_8B_C;
      16:      return VIP_AXI4_SIZE_16B_C;
      32:      return VIP_AXI4_SIZE_32B_C;
      64:      return VIP_AXI4_SIZE_64B_C;
      128:     return VIP_AXI4_SIZE_128B_C;
      default: return VIP_AXI4_SIZE_1B_C;
    endcase
  endfunction

  // EXOKAY ranks with OKAY: a merged status only reports failures.
  function automatic vip_axi4_resp_t worst_resp(input vip_axi4_resp_t a, input vip_axi4_resp_t b);
    if (a == VIP_AXI4_RESP_DECERR_C || b == VIP_AXI4_RESP_DECERR_C) return VIP_AXI4_RESP_DECERR_C;
    if (a == VIP_AXI4_RESP_SLVERR_C || b == VIP_AXI4_RESP_SLVERR_C) return VIP_AXI4_RESP_SLVERR_C;
    return VIP_AXI4_RESP_OKAY_C;
  endfunction

endpackage

// File: rtl/vip_axi4_burst_len_calc.sv
// rtl/vip_axi4_burst_len_calc.sv - beats for the next INCR burst (len cap, 4 KB cap, remaining)
module vip_axi4_burst_len_calc
  import vip_axi4_types_pkg::*;
#(
  parameter int DATA_WIDTH_P    = 64,
  parameter int LEN_WIDTH_P     = 20,
  parameter int MAX_BURST_LEN_P = 256
) (
  input  logic [11:0]            addr,
  input  logic [LEN_WIDTH_P-1:0] remaining,
  output logic [8:0]             n
);

  localparam int SIZE_LOG2_C = $clog2(DATA_WIDTH_P / 8);
  localparam int CW_C        = (LEN_WIDTH_P > 13) ? LEN_WIDTH_P : 13;

  logic [12:0]     w_to_4k_bytes;
  logic [CW_C-1:0] w_to_4k_beats;
  logic [CW_C-1:0] w_cap;
  logic [CW_C-1:0] w_rem;
  logic [CW_C-1:0] w_n;

  // addr is beat-aligned, so the byte distance divides exactly into beats
  assign w_to_4k_bytes = 13'(VIP_AXI4_4K_ADDRESS_BOUNDARY_C) - {1'b0, addr};
  assign w_to_4k_beats = CW_C'(w_to_4k_bytes >> SIZE_LOG2_C);
  assign w_cap = (w_to_4k_beats < CW_C'(MAX_BURST_LEN_P)) ? w_to_4k_beats : CW_C'(MAX_BURST_LEN_P);
  assign w_rem = CW_C'(remaining);
  assign w_n   = (w_rem < w_cap) ? w_rem : w_cap;
  assign n     = 9'(w_n);

endmodule

// File: rtl/vip_axi4_rd_burst_ctrl.sv
// rtl/vip_axi4_rd_burst_ctrl.sv - splits a read command into 4 KB-safe INCR bursts and streams R data
module vip_axi4_rd_burst_ctrl
  import vip_axi4_types_pkg::*;
#(
  parameter int ID_WIDTH_P        = 4,
  parameter int ADDR_WIDTH_P      = 32,
  parameter int DATA_WIDTH_P      = 64,
  parameter int LEN_WIDTH_P       = 20,
  parameter int MAX_BURST_LEN_P   = 256,
  parameter int MAX_OUTSTANDING_P = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [LEN_WIDTH_P-1:0]  cmd_beats,
  input  logic [ID_WIDTH_P-1:0]   cmd_id,
  output logic [ID_WIDTH_P-1:0]   arid,
  output logic [ADDR_WIDTH_P-1:0] araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH_P-1:0] rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [DATA_WIDTH_P-1:0] dout_data,
  output logic                    dout_valid,
  output logic                    dout_last,
  input  logic                    dout_ready,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    busy
);

  localparam int BYTES_C     = DATA_WIDTH_P / 8;
  localparam int SIZE_LOG2_C = $clog2(BYTES_C);

  vip_axi4_rd_ctrl_state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH_P-1:0] r_addr;
  logic [LEN_WIDTH_P-1:0]  r_remaining;
  logic [LEN_WIDTH_P-1:0]  r_total;
  logic [LEN_WIDTH_P-1:0]  r_rx_cnt;
  logic [ID_WIDTH_P-1:0]   r_id;
  vip_axi4_resp_t          r_acc_resp;
  logic [4:0]              r_outstanding, w_outstanding_nxt;
  logic [8:0]              w_n;
  logic                    w_issue, w_active;
  logic                    w_cmd_hs, w_ar_hs, w_r_hs, w_rlast_hs;

  vip_axi4_burst_len_calc #(
    .DATA_WIDTH_P    (DATA_WIDTH_P),
    .LEN_WIDTH_P     (LEN_WIDTH_P),
    .MAX_BURST_LEN_P (MAX_BURST_LEN_P)
  ) u_len_calc (
    .addr      (r_addr[11:0]),
    .remaining (r_remaining),
    .n         (w_n)
  );

  assign w_issue  = (r_state == VIP_AXI4_RD_ISSUE_C);
  assign w_active = w_issue || (r_state == VIP_AXI4_RD_DRAIN_C);

  // IDLE is the reset state, so cmd_ready is qualified to stay low while reset is held
  assign cmd_ready = rst_n && (r_state == VIP_AXI4_RD_IDLE_C);
  assign busy      = (r_state != VIP_AXI4_RD_IDLE_C);

  assign arvalid = w_issue && (r_outstanding < 5'(MAX_OUTSTANDING_P));
  assign araddr  = w_issue ? r_addr : '0;
  assign arlen   = w_issue ? 8'(w_n - 9'd1) : '0;
  assign arid    = w_issue ? r_id : '0;
  assign arsize  = w_issue ? 3'(size_as_enum(BYTES_C)) : '0;
  assign arburst = w_issue ? VIP_AXI4_BURST_INCR_C : '0;

  assign rready     = w_active && dout_ready;
  assign dout_valid = w_active && rvalid;
  assign dout_data  = w_active ? rdata : '0;
  assign dout_last  = dout_valid && (r_rx_cnt == r_total - LEN_WIDTH_P'(1));

  assign done_valid = (r_state == VIP_AXI4_RD_DONE_C);
  assign done_resp  = done_valid ? 2'(r_acc_resp) : '0;

  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign w_ar_hs    = arvalid && arready;
  assign w_r_hs     = rvalid && rready;
  assign w_rlast_hs = w_r_hs && rlast;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_ar_hs && !w_rlast_hs)      w_outstanding_nxt = r_outstanding + 5'd1;
    else if (!w_ar_hs && w_rlast_hs) w_outstanding_nxt = r_outstanding - 5'd1;
  end

  // DRAIN looks at the next outstanding count so done_valid follows the last rlast by one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VIP_AXI4_RD_IDLE_C:
        if (w_cmd_hs) w_state_nxt = (cmd_beats != '0) ? VIP_AXI4_RD_ISSUE_C : VIP_AXI4_RD_DONE_C;
      VIP_AXI4_RD_ISSUE_C:
        if (w_ar_hs && (r_remaining == LEN_WIDTH_P'(w_n))) w_state_nxt = VIP_AXI4_RD_DRAIN_C;
      VIP_AXI4_RD_DRAIN_C:
        if (w_outstanding_nxt == '0) w_state_nxt = VIP_AXI4_RD_DONE_C;
      VIP_AXI4_RD_DONE_C:
        w_state_nxt = VIP_AXI4_RD_IDLE_C;
      default:
        w_state_nxt = VIP_AXI4_RD_IDLE_C;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= VIP_AXI4_RD_IDLE_C;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_total       <= '0;
      r_rx_cnt      <= '0;
      r_id          <= '0;
      r_acc_resp    <= VIP_AXI4_RESP_OKAY_C;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr & ~ADDR_WIDTH_P'(BYTES_C - 1);
        r_remaining <= cmd_beats;
        r_total     <= cmd_beats;
        r_id        <= cmd_id;
        r_acc_resp  <= VIP_AXI4_RESP_OKAY_C;
        r_rx_cnt    <= '0;
      end
      if (w_ar_hs) begin
        r_addr      <= r_addr + (ADDR_WIDTH_P'(w_n) << SIZE_LOG2_C);
        r_remaining <= r_remaining - LEN_WIDTH_P'(w_n);
      end
      if (w_r_hs) begin
        r_rx_cnt   <= r_rx_cnt + LEN_WIDTH_P'(1);
        r_acc_resp <= worst_resp(r_acc_resp, vip_axi4_resp_t'(rresp));
      end
    end
  end

endmodule

// File: tb/tb_vip_axi4_rd_burst_ctrl.sv
// tb/tb_vip_axi4_rd_burst_ctrl.sv - scoreboard bench for vip_axi4_rd_burst_ctrl with a reactive AXI slave
module tb_vip_axi4_rd_burst_ctrl;

  localparam int MAX_OUT_C = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [19:0] cmd_beats = '0;
  logic [3:0]  cmd_id = '0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [63:0] dout_data;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        busy;

  vip_axi4_rd_burst_ctrl #(
    .ID_WIDTH_P(4), .ADDR_WIDTH_P(32), .DATA_WIDTH_P(64), .LEN_WIDTH_P(20),
    .MAX_BURST_LEN_P(256), .MAX_OUTSTANDING_P(MAX_OUT_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .done_valid(done_valid),
    .done_resp(done_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [43:0] exp_ar[$];
  logic [64:0] exp_beat[$];
  logic [1:0]  exp_done[$];

  int         cur_tag = 0;
  int         cfg_gap = 0;
  bit         cfg_sync = 1'b0;
  int         cfg_bp_at = -1;
  logic [1:0] cfg_def = 2'b00;
  int         cfg_e0_idx = -1;
  logic [1:0] cfg_e0 = 2'b00;
  int         cfg_e1_idx = -1;
  logic [1:0] cfg_e1 = 2'b00;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event/timeout expected none", nm);
  endtask

  function automatic logic [63:0] mk_data(input int tag, input int beat);
    return {16'(tag), 16'hC0DE, 32'(beat)};
  endfunction

  function automatic logic [1:0] resp_for(input int beat);
    if (beat == cfg_e0_idx) return cfg_e0;
    if (beat == cfg_e1_idx) return cfg_e1;
    return cfg_def;
  endfunction

  function automatic logic [127:0] out_vec();
    return 128'({cmd_ready, arvalid, araddr, arlen, arsize, arburst, arid, rready, dout_valid,
                 dout_last, dout_data, done_valid, done_resp, busy});
  endfunction

  // Slave: drives at negedge, records handshakes at negedge+2 (before the next posedge)
  int slv_len_q[$];
  int slv_beat = 0, burst_pos = 0, gap_cnt = 0, out_cnt = 0, bp_left = 0, dout_cnt = 0, dcyc = 0;
  bit r_taken = 1'b0;

  initial begin
    rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; arready = 1'b0; dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slv_len_q.delete();
        burst_pos = 0; gap_cnt = 0; out_cnt = 0; bp_left = 0; r_taken = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; arready = 1'b0; dout_ready = 1'b1;
      end else begin
        if (bp_left > 0) begin dout_ready = 1'b0; bp_left--; end
        else dout_ready = 1'b1;
        if (r_taken) rvalid = 1'b0;
        r_taken = 1'b0;
        if (!rvalid && slv_len_q.size() > 0) begin
          if (gap_cnt >= cfg_gap) begin
            rvalid = 1'b1;
            rdata  = mk_data(cur_tag, slv_beat);
            rresp  = resp_for(slv_beat);
            rlast  = (burst_pos == slv_len_q[0] - 1);
          end else gap_cnt++;
        end
        if (!rvalid) rlast = 1'b0;
        if (cfg_sync) arready = (out_cnt == 0) || (rvalid && rlast && dout_ready);
        else          arready = (dcyc % 3 != 2);
        dcyc++;
      end
      #2;
      if (rst_n) begin
        if (arvalid && arready) begin
          slv_len_q.push_back(int'(arlen) + 1);
          out_cnt++;
        end
        if (rvalid && rready) begin
          r_taken = 1'b1;
          slv_beat++;
          dout_cnt++;
          if (dout_cnt == cfg_bp_at) bp_left = 10;
          if (rlast) begin
            void'(slv_len_q.pop_front());
            burst_pos = 0; gap_cnt = 0; out_cnt--;
          end else burst_pos++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer
  int          cyc = 0, ref_cyc = 0, ar_due = -1, mon_out = 0;
  bit          stall = 1'b0;
  logic [43:0] stall_v = '0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst_n) begin
        mon_out = 0; stall = 1'b0; ar_due = -1;
      end else begin
        if (cmd_valid && cmd_ready) begin
          ref_cyc = cyc;
          if (cmd_beats != 0) ar_due = cyc + 1;
        end
        if (cyc == ar_due) chk("ar_latency", arvalid, 1'b1);
        if (mon_out >= MAX_OUT_C) chk("ar_cap", arvalid, 1'b0);
        if (stall) chk("ar_stable", {arvalid, arid, araddr, arlen}, {1'b1, stall_v});
        stall   = arvalid && !arready;
        stall_v = {arid, araddr, arlen};
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else chk("ar_fields", {arid, araddr, arlen, arsize, arburst}, {exp_ar.pop_front(), 3'd3, 2'b01});
        end
        if (busy && !dout_ready) chk("rready_bp", rready, 1'b0);
        if (dout_valid && dout_ready) begin
          if (exp_beat.size() == 0) fail_now("beat_unexpected");
          else chk("dout_beat", {dout_last, dout_data}, exp_beat.pop_front());
          if (dout_last) ref_cyc = cyc;
        end
        if (done_valid) begin
          chk("done_latency", cyc, ref_cyc + 1);
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else chk("done_resp", done_resp, exp_done.pop_front());
        end
        if ((arvalid && arready) && !(rvalid && rready && rlast)) mon_out++;
        else if (!(arvalid && arready) && (rvalid && rready && rlast)) mon_out--;
      end
    end
  end

  task automatic set_cfg(input int gap, input bit sync, input int bp_at, input logic [1:0] def,
                         input int e0i, input logic [1:0] e0, input int e1i, input logic [1:0] e1);
    cfg_gap = gap; cfg_sync = sync; cfg_bp_at = bp_at; cfg_def = def;
    cfg_e0_idx = e0i; cfg_e0 = e0; cfg_e1_idx = e1i; cfg_e1 = e1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input int beats, input logic [3:0] id);
    bit acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 20'(beats); cmd_id = id;
    for (int k = 0; k < 100 && !acc; k++) begin
      #1;
      if (cmd_ready) acc = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!acc) fail_now("cmd_accept_timeout");
  endtask

  task automatic run_cmd(input logic [31:0] a, input int beats, input logic [3:0] id,
                         input logic [1:0] exp_resp, input int nar,
                         input logic [31:0] a0, input logic [7:0] l0,
                         input logic [31:0] a1, input logic [7:0] l1,
                         input logic [31:0] a2, input logic [7:0] l2);
    int k;
    cur_tag++; slv_beat = 0; dout_cnt = 0;
    if (nar > 0) exp_ar.push_back({id, a0, l0});
    if (nar > 1) exp_ar.push_back({id, a1, l1});
    if (nar > 2) exp_ar.push_back({id, a2, l2});
    for (int i = 0; i < beats; i++) exp_beat.push_back({(i == beats - 1), mk_data(cur_tag, i)});
    exp_done.push_back(exp_resp);
    send_cmd(a, beats, id);
    for (k = 0; k < 20000 && (exp_done.size() != 0 || exp_beat.size() != 0); k++) @(negedge clk);
    if (k >= 20000) begin
      fail_now("cmd_done_timeout");
      exp_done.delete(); exp_beat.delete();
    end
    if (exp_ar.size() != 0) begin
      fail_now("ar_missing");
      exp_ar.delete();
    end
  endtask

  initial begin
    #3;
    chk("reset_outputs", out_vec(), '0);
    #19 rst_n = 1'b1;
    @(negedge clk); #4;
    chk("idle_after_reset", {cmd_ready, busy}, 2'b10);

    set_cfg(0, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h0, 16, 4'h3, 2'b00, 1, 32'h0, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);
    set_cfg(2, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h0FC0, 32, 4'h5, 2'b00, 2, 32'h0FC0, 8'd7, 32'h1000, 8'd23, 32'h0, 8'd0);
    set_cfg(8, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h0, 600, 4'h1, 2'b00, 3, 32'h0, 8'd255, 32'h800, 8'd255, 32'h1000, 8'd87);
    set_cfg(1, 0, -1, 2'b00, 260, 2'b10, -1, 2'b00);
    run_cmd(32'h0, 300, 4'h2, 2'b10, 2, 32'h0, 8'd255, 32'h800, 8'd43, 32'h0, 8'd0);
    set_cfg(1, 0, -1, 2'b00, 260, 2'b10, 10, 2'b11);
    run_cmd(32'h0, 300, 4'h2, 2'b11, 2, 32'h0, 8'd255, 32'h800, 8'd43, 32'h0, 8'd0);
    set_cfg(0, 0, -1, 2'b01, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h100, 20, 4'h6, 2'b00, 1, 32'h100, 8'd19, 32'h0, 8'd0, 32'h0, 8'd0);
    set_cfg(0, 0, 5, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h40, 40, 4'h9, 2'b00, 1, 32'h40, 8'd39, 32'h0, 8'd0, 32'h0, 8'd0);
    set_cfg(0, 1, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h0, 600, 4'hA, 2'b00, 3, 32'h0, 8'd255, 32'h800, 8'd255, 32'h1000, 8'd87);
    set_cfg(0, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h123, 0, 4'h7, 2'b00, 0, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);
    run_cmd(32'h0FFC, 3, 4'hB, 2'b00, 2, 32'h0FF8, 8'd0, 32'h1000, 8'd1, 32'h0, 8'd0);
    run_cmd(32'hFFFF_FFF8, 2, 4'hC, 2'b00, 2, 32'hFFFF_FFF8, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);

    // abort while draining: the single burst is accepted but its data is held back
    set_cfg(40, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    cur_tag++; slv_beat = 0; dout_cnt = 0;
    exp_ar.push_back({4'hD, 32'h0, 8'd63});
    send_cmd(32'h0, 64, 4'hD);
    for (int k = 0; k < 100 && exp_ar.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    chk("drain_state", {busy, arvalid, exp_ar.size() == 0}, 3'b101);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), '0);
    exp_ar.delete(); exp_beat.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #4;
    chk("idle_after_abort", {cmd_ready, busy, arvalid}, 3'b100);

    set_cfg(0, 0, -1, 2'b00, -1, 2'b00, -1, 2'b00);
    run_cmd(32'h0, 16, 4'h4, 2'b00, 1, 32'h0, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
